imm_gen_stage: RTL and testbench

Registered, flow-controlled immediate generator for the decode stage. Takes a full 32-bit RISC-V instruction plus a sideband tag, selects the immediate format from the opcode or from an explicit selector, and produces the sign- or zero-extended immediate at XLEN width. A 2-entry skid buffer gives full throughput with a registered `in_ready`. It replaces the purely combinational 25-bit immediate path with a pipelined, back-pressurable stage that also handles RV64 and the CSR and shift immediates.

---
 rtl/imm_pkg.sv | 38 +++
 rtl/imm_gen_stage_if.sv | 30 +++
 rtl/imm_extract.sv | 61 ++++++
 rtl/imm_gen_stage.sv | 106 ++++++++++
 tb/tb_imm_gen_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared types for the immediate generator stage: format codes, base opcodes,
// skid-buffer occupancy states and the per-entry decode metadata.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_S     = 3'd1,
    FMT_B     = 3'd2,
    FMT_J     = 3'd3,
    FMT_U     = 3'd4,
    FMT_JALR  = 3'd5,
    FMT_Z     = 3'd6,
    FMT_SHAMT = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // Width-independent part of a buffer entry; imm and tag widths come from the stage parameters.
  typedef struct packed {
    fmt_e fmt;
    logic unk;
  } entry_meta_t;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for the immediate generator: input beat channel and output beat channel.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             in_auto;
  logic [2:0]       in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  logic             out_unk;

  modport slave (
    input  in_valid, in_inst, in_tag, in_auto, in_sel, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag, out_unk
  );

  modport master (
    output in_valid, in_inst, in_tag, in_auto, in_sel, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag, out_unk
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extraction: picks the format (auto from opcode or explicit)
// and produces the sign/zero-extended immediate at XLEN width.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic            auto_mode,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            unk
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    fmt = fmt_e'(sel);
    unk = 1'b0;
    if (auto_mode) begin
      fmt = FMT_I;
      case (opcode)
        OPC_LOAD:          fmt = FMT_I;
        OPC_OP_IMM:        fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
        OPC_STORE:         fmt = FMT_S;
        OPC_BRANCH:        fmt = FMT_B;
        OPC_JAL:           fmt = FMT_J;
        OPC_LUI,
        OPC_AUIPC:         fmt = FMT_U;
        OPC_JALR:          fmt = FMT_JALR;
        OPC_SYSTEM:        fmt = funct3[2] ? FMT_Z : FMT_I;
        default:           unk = 1'b1;
      endcase
    end
  end

  // Signed size casts do the sign extension; U only grows beyond 32 bits on RV64.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:     imm = XLEN'($signed(inst[31:20]));
      FMT_S:     imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      FMT_B:     imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      FMT_J:     imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      FMT_U:     imm = XLEN'($signed({inst[31:12], 12'b0}));
      FMT_JALR:  imm = XLEN'($signed({inst[31:21], 1'b0}));
      FMT_Z:     imm = XLEN'(inst[19:15]);
      FMT_SHAMT: imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      default:   imm = '0;
    endcase
    if (unk) begin
      imm = '0;
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage: extraction in front of a 2-entry skid buffer
// so in_ready is a pure register decode and the stage still sustains one beat per cycle.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  imm_gen_stage_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    entry_meta_t      meta;
    logic [TAG_W-1:0] tag;
  } entry_t;

  occ_e            state_q, state_d;
  entry_t          head_q, head_d;
  entry_t          tail_q, tail_d;
  entry_t          new_entry;
  logic [XLEN-1:0] ext_imm;
  fmt_e            ext_fmt;
  logic            ext_unk;
  logic            accept;
  logic            pop;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .inst      (bus.in_inst),
    .auto_mode (bus.in_auto),
    .sel       (bus.in_sel),
    .imm       (ext_imm),
    .fmt       (ext_fmt),
    .unk       (ext_unk)
  );

  always_comb begin
    new_entry          = '0;
    new_entry.imm      = ext_imm;
    new_entry.meta.fmt = ext_fmt;
    new_entry.meta.unk = ext_unk;
    new_entry.tag      = bus.in_tag;
  end

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // head always feeds the outputs; tail only holds the beat that arrived while head was stalled.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = new_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_d = new_entry;
          end else if (accept) begin
            tail_d  = new_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign bus.out_imm = head_q.imm;
  assign bus.out_fmt = head_q.meta.fmt;
  assign bus.out_unk = head_q.meta.unk;
  assign bus.out_tag = head_q.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench: drives an RV32 and an RV64 instance with identical traffic and
// compares both against a queue-based behavioural model every cycle.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_auto;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_tag;
  logic [2:0]  in_sel;

  int checks = 0;
  int errors = 0;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.in_inst   = in_inst;
  assign b32.in_tag    = in_tag;
  assign b32.in_auto   = in_auto;
  assign b32.in_sel    = in_sel;
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.in_inst   = in_inst;
  assign b64.in_tag    = in_tag;
  assign b64.in_auto   = in_auto;
  assign b64.in_sel    = in_sel;
  assign b64.out_ready = out_ready;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        am;
    logic [2:0]  sel;
    logic [31:0] tag;
  } beat_t;

  beat_t q[$];
  bit    after_reset = 0;
  bit    started = 0;

  logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h67, 7'h73};

  function automatic longint sx(longint x, int w);
    if (x >= (longint'(1) << (w - 1))) return x - (longint'(1) << w);
    return x;
  endfunction

  // Returns {unk, fmt[2:0], imm[63:0]}; the RV32 instance is compared on imm[31:0].
  function automatic logic [67:0] model(logic [31:0] i, logic am, logic [2:0] s, bit x64);
    longint      v;
    int          f;
    bit          unk;
    logic [2:0]  f3;
    logic [63:0] vb;
    unk = 0;
    f3  = i[14:12];
    f   = s;
    if (am) begin
      case (i[6:0])
        7'h03:        f = 0;
        7'h13:        f = (f3 == 3'd1 || f3 == 3'd5) ? 7 : 0;
        7'h23:        f = 1;
        7'h63:        f = 2;
        7'h6F:        f = 3;
        7'h37, 7'h17: f = 4;
        7'h67:        f = 5;
        7'h73:        f = f3[2] ? 6 : 0;
        default: begin f = 0; unk = 1; end
      endcase
    end
    case (f)
      0: v = sx(longint'(i[31:20]), 12);
      1: v = sx(longint'({i[31:25], i[11:7]}), 12);
      2: v = sx(longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
      3: v = sx(longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
      4: v = sx(longint'(i[31:12]), 20) * 4096;
      5: v = sx(longint'(i[31:20]), 12) & ~longint'(1);
      6: v = longint'(i[19:15]);
      default: v = x64 ? longint'(i[25:20]) : longint'(i[24:20]);
    endcase
    if (unk) v = 0;
    vb = v;
    return {unk, 3'(f), vb};
  endfunction

  task automatic checkOutput(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic am,
                               input logic [2:0] s, input logic [31:0] tag,
                               input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_inst   = inst;
    in_auto   = am;
    in_sel    = s;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Reference queue advances on each edge from the inputs the DUT saw at that edge.
  always @(posedge clk) begin : model_upd
    bit acc;
    bit pp;
    if (rst) begin
      q.delete();
      after_reset = 1;
      started = 1;
    end else if (flush) begin
      q.delete();
      after_reset = 0;
    end else begin
      acc = in_valid && (q.size() != 2);
      pp  = (q.size() != 0) && out_ready;
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back('{inst: in_inst, am: in_auto, sel: in_sel, tag: in_tag});
        after_reset = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [67:0] e32;
    logic [67:0] e64;
    if (started) begin
      checkOutput("in_ready32", b32.in_ready, q.size() != 2);
      checkOutput("in_ready64", b64.in_ready, q.size() != 2);
      checkOutput("out_valid32", b32.out_valid, q.size() != 0);
      checkOutput("out_valid64", b64.out_valid, q.size() != 0);
      if (q.size() > 0) begin
        e32 = model(q[0].inst, q[0].am, q[0].sel, 0);
        e64 = model(q[0].inst, q[0].am, q[0].sel, 1);
        checkOutput("imm32", b32.out_imm, e32[31:0]);
        checkOutput("fmt32", b32.out_fmt, e32[66:64]);
        checkOutput("unk32", b32.out_unk, e32[67]);
        checkOutput("tag32", b32.out_tag, q[0].tag);
        checkOutput("imm64", b64.out_imm, e64[63:0]);
        checkOutput("fmt64", b64.out_fmt, e64[66:64]);
        checkOutput("unk64", b64.out_unk, e64[67]);
        checkOutput("tag64", b64.out_tag, q[0].tag);
      end else if (after_reset) begin
        checkOutput("rst_fields32", {b32.out_imm, b32.out_fmt, b32.out_unk, b32.out_tag}, 68'd0);
        checkOutput("rst_fields64", {b64.out_imm, b64.out_fmt, b64.out_unk, b64.out_tag}, 68'd0);
      end
    end
  end

  initial begin : stim
    logic [31:0] r;
    rst = 1; flush = 0; in_valid = 0; in_inst = 0; in_auto = 1; in_sel = 0; in_tag = 0; out_ready = 0;

    checkOutput("model_addi",   model(32'hFFF00093, 1, 0, 0), {1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    checkOutput("model_jal",    model(32'hFFDFF06F, 1, 0, 0), {1'b0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC});
    checkOutput("model_jalr",   model(32'h00D08067, 1, 0, 0), {1'b0, 3'd5, 64'h0C});
    checkOutput("model_lui64",  model(32'h800002B7, 1, 0, 1), {1'b0, 3'd4, 64'hFFFF_FFFF_8000_0000});
    checkOutput("model_csr",    model(32'h300FD073, 1, 0, 0), {1'b0, 3'd6, 64'h1F});
    checkOutput("model_slli64", model(32'h02109093, 1, 0, 1), {1'b0, 3'd7, 64'd33});
    checkOutput("model_slli32", model(32'h02109093, 1, 0, 0), {1'b0, 3'd7, 64'd1});
    checkOutput("model_unk",    model(32'hFE000FFF, 1, 0, 0), {1'b1, 3'd0, 64'd0});
    checkOutput("model_manB",   model(32'hFE000FFF, 0, 2, 0), {1'b0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFE});

    repeat (2) @(posedge clk);
    #1 rst = 0;
    checkOutput("reset_in_ready", b32.in_ready, 1);
    checkOutput("reset_out_valid", b32.out_valid, 0);

    applyStimulus(1, 32'hFFF00093, 1, 0, 32'h11, 1, 0);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0);
    checkOutput("addi_imm", b32.out_imm, 32'hFFFF_FFFF);
    checkOutput("addi_fmt", {b32.out_valid, b32.out_fmt, b32.out_unk}, 5'b1_000_0);

    applyStimulus(1, 32'hFFDFF06F, 1, 0, 32'h21, 1, 0);
    applyStimulus(1, 32'h00D08067, 1, 0, 32'h22, 1, 0);
    checkOutput("jal_imm", {b32.out_fmt, b32.out_imm}, {3'd3, 32'hFFFF_FFFC});
    applyStimulus(1, 32'h800002B7, 1, 0, 32'h23, 1, 0);
    checkOutput("jalr_imm", {b32.out_fmt, b32.out_imm}, {3'd5, 32'h0000_000C});
    applyStimulus(1, 32'h300FD073, 1, 0, 32'h24, 1, 0);
    checkOutput("lui64_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
    checkOutput("lui32_imm", b32.out_imm, 32'h8000_0000);
    applyStimulus(1, 32'h02109093, 1, 0, 32'h25, 1, 0);
    checkOutput("csr_imm", {b32.out_fmt, b32.out_imm}, {3'd6, 32'h1F});
    applyStimulus(1, 32'hFE000FFF, 1, 0, 32'h26, 1, 0);
    checkOutput("slli64_imm", {b64.out_fmt, b64.out_imm}, {3'd7, 64'd33});
    checkOutput("slli32_imm", b32.out_imm, 32'd1);
    applyStimulus(1, 32'hFE000FFF, 0, 2, 32'h27, 1, 0);
    checkOutput("unk_auto", {b32.out_unk, b32.out_fmt, b32.out_imm}, {1'b1, 3'd0, 32'd0});
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0);
    checkOutput("manual_b", {b32.out_unk, b32.out_fmt, b32.out_imm}, {1'b0, 3'd2, 32'hFFFF_FFFE});

    applyStimulus(1, 32'h00100093, 1, 0, 32'hA, 0, 0);
    applyStimulus(1, 32'h00200093, 1, 0, 32'hB, 0, 0);
    applyStimulus(1, 32'h00300093, 1, 0, 32'hC, 0, 0);
    checkOutput("bp_in_ready_low", b32.in_ready, 0);
    checkOutput("bp_head_a", b32.out_tag, 32'hA);
    applyStimulus(1, 32'h00300093, 1, 0, 32'hC, 0, 0);
    applyStimulus(1, 32'h00300093, 1, 0, 32'hC, 1, 0);
    applyStimulus(1, 32'h00300093, 1, 0, 32'hC, 1, 0);
    checkOutput("bp_head_b", {b32.out_valid, b32.out_tag}, {1'b1, 32'hB});
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0);
    checkOutput("bp_head_c", {b32.out_valid, b32.out_tag}, {1'b1, 32'hC});
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 0, 0);
    checkOutput("bp_drained", b32.out_valid, 0);

    applyStimulus(1, 32'h00400093, 1, 0, 32'hD, 0, 0);
    applyStimulus(1, 32'h00500093, 1, 0, 32'hE, 0, 0);
    applyStimulus(1, 32'h00600093, 1, 0, 32'hF, 0, 1);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 0, 0);
    checkOutput("flush_full", {b32.out_valid, b32.in_ready}, 2'b01);
    applyStimulus(1, 32'h00700093, 1, 0, 32'h70, 0, 0);
    applyStimulus(1, 32'h00800093, 1, 0, 32'h80, 1, 1);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0);
    checkOutput("flush_one_accept", {b32.out_valid, b32.in_ready}, 2'b01);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      if ($urandom_range(0, 4) != 0) r[6:0] = ops[$urandom_range(0, 8)];
      applyStimulus($urandom_range(0, 9) < 7, r, $urandom_range(0, 3) != 0,
                    3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
    end

    rst = 0;
    repeat (4) applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
